// File: rtl/key_expand_seq.sv
// key_expand_seq: sequential AES-128/192/256 key expansion emitting one 128-bit round key per four words
module key_expand_seq #(
  parameter int KEY192_EN = 1,
  parameter int KEY256_EN = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [255:0] key,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_index,
  output logic         rk_valid,
  output logic         busy,
  output logic         done,
  output logic         err
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction
  state_t         state_q, state_d;
  logic [255:0]   key_q, key_d;
  logic [1:0]     mode_q, mode_d;
  logic [7:0][31:0] win_q, win_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [3:0]     j_q, j_d;
  logic [7:0]     rcon_q, rcon_d;
  logic [127:0]   rk_out_q, rk_out_d;
  logic [3:0]     rk_index_q, rk_index_d;
  logic           rk_valid_q, rk_valid_d;
  logic           err_q, err_d;
  logic [3:0]     nk, nr;
  logic [5:0]     nwords;
  logic           bad, acc, gen, first;
  logic [31:0]    prev, old, temp, w_new;
  assign rk_out   = rk_out_q;
  assign rk_index = rk_index_q;
  assign rk_valid = rk_valid_q;
  assign busy     = state_q != IDLE;
  assign err      = err_q;
  assign done     = acc && rk_index_q == nr;
  // Key-size geometry, stall decision and the next expanded word from the sliding window
  always_comb begin
    nk     = mode_q == 2'd0 ? 4'd4 : mode_q == 2'd1 ? 4'd6 : 4'd8;
    nr     = nk + 4'd6;
    nwords = {nr, 2'b00} + 6'd4;
    bad    = mode == 2'd3 || (mode == 2'd1 && KEY192_EN == 0) || (mode == 2'd2 && KEY256_EN == 0);
    acc    = rk_valid_q && rk_ready;
    gen    = state_q != IDLE && cnt_q != nwords && !(rk_valid_q && !rk_ready);
    first  = cnt_q < {2'b00, nk};
    prev   = win_q[0];
    old    = nk == 4'd4 ? win_q[3] : nk == 4'd6 ? win_q[5] : win_q[7];
    temp   = j_q == 4'd0 ? sub_word({prev[23:0], prev[31:24]}) ^ {rcon_q, 24'h0} :
             (nk == 4'd8 && j_q == 4'd4) ? sub_word(prev) : prev;
    w_new  = first ? key_q[255:224] : old ^ temp;
  end
  // Next state: capture on start, advance one word per unstalled cycle, pack every fourth word
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    mode_d     = mode_q;
    win_d      = win_q;
    cnt_d      = cnt_q;
    j_d        = j_q;
    rcon_d     = rcon_q;
    rk_out_d   = rk_out_q;
    rk_index_d = rk_index_q;
    rk_valid_d = acc ? 1'b0 : rk_valid_q;
    err_d      = state_q == IDLE && start && bad;
    if (state_q == IDLE && start && !bad) begin
      state_d = RUN;
      key_d   = key;
      mode_d  = mode;
      win_d   = '0;
      cnt_d   = '0;
      j_d     = '0;
      rcon_d  = 8'h01;
    end
    if (gen) begin
      key_d  = {key_q[223:0], 32'h0};
      win_d  = {win_q[6:0], w_new};
      cnt_d  = cnt_q + 6'd1;
      j_d    = j_q == nk - 4'd1 ? 4'd0 : j_q + 4'd1;
      rcon_d = (!first && j_q == 4'd0) ? {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00) : rcon_q;
      if (cnt_q[1:0] == 2'd3) begin
        rk_out_d   = {win_q[2], win_q[1], win_q[0], w_new};
        rk_index_d = cnt_q[5:2];
        rk_valid_d = 1'b1;
      end
    end
    if (state_q != IDLE)
      state_d = (acc && rk_index_q == nr) ? IDLE : (rk_valid_q && !rk_ready) ? HOLD : RUN;
  end
  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      key_q      <= '0;
      mode_q     <= 2'd0;
      win_q      <= '0;
      cnt_q      <= '0;
      j_q        <= '0;
      rcon_q     <= 8'h01;
      rk_out_q   <= '0;
      rk_index_q <= '0;
      rk_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      mode_q     <= mode_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      j_q        <= j_d;
      rcon_q     <= rcon_d;
      rk_out_q   <= rk_out_d;
      rk_index_q <= rk_index_d;
      rk_valid_q <= rk_valid_d;
      err_q      <= err_d;
    end
  end
endmodule
